// File: rtl/pll_bringup_seq.sv
// PLL bring-up sequencer: pulses PLL reset, filters lock, staggers the output
// enables, releases the system reset, then supervises lock and retries on timeout.
module pll_bringup_seq #(
    parameter int unsigned NUM_CLK        = 5,
    parameter int unsigned RST_CYCLES     = 16,
    parameter int unsigned LOCK_FILT      = 64,
    parameter int unsigned ENCLK_GAP      = 8,
    parameter int unsigned RELOCK_TIMEOUT = 100000,
    parameter int unsigned MAX_RETRY      = 3,
    localparam int unsigned RETRY_W      = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
    input  logic               clkin,
    input  logic               reset,
    input  logic               pll_lock,
    input  logic               force_relock,
    output logic               pll_reset,
    output logic [NUM_CLK-1:0] enclk,
    output logic               sys_reset,
    output logic               locked,
    output logic               fail,
    output logic               lock_lost,
    output logic [RETRY_W-1:0] retry_cnt
);

    localparam int unsigned MAX_A   = (RST_CYCLES > LOCK_FILT) ? RST_CYCLES : LOCK_FILT;
    localparam int unsigned MAX_B   = (ENCLK_GAP > RELOCK_TIMEOUT) ? ENCLK_GAP : RELOCK_TIMEOUT;
    localparam int unsigned CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned IDX_W   = (NUM_CLK > 1) ? $clog2(NUM_CLK) : 1;

    localparam logic [2:0] S_RESET_PLL = 3'd0;
    localparam logic [2:0] S_WAIT_LOCK = 3'd1;
    localparam logic [2:0] S_FILTER    = 3'd2;
    localparam logic [2:0] S_ENABLE    = 3'd3;
    localparam logic [2:0] S_RUN       = 3'd4;
    localparam logic [2:0] S_FAIL      = 3'd5;

    logic [2:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               lock_meta, lock_s;
    logic               pll_reset_d, sys_reset_d, locked_d, fail_d, lock_lost_d;
    logic [NUM_CLK-1:0] enclk_d;
    logic [RETRY_W-1:0] retry_d;

    // Two-flop synchronizer for the asynchronous PLL lock indication
    always_ff @(posedge clkin) begin
        if (reset) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= pll_lock;
            lock_s    <= lock_meta;
        end
    end

    // Next-state and next-output logic; force_relock overrides every state
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        pll_reset_d = pll_reset;
        enclk_d     = enclk;
        sys_reset_d = sys_reset;
        locked_d    = locked;
        fail_d      = fail;
        lock_lost_d = lock_lost;
        retry_d     = retry_cnt;
        cnt_inc     = (cnt_q == CNT_W'(CNT_MAX)) ? cnt_q : cnt_q + CNT_W'(1);

        if (force_relock) begin
            state_d     = S_RESET_PLL;
            cnt_d       = '0;
            idx_d       = '0;
            pll_reset_d = 1'b1;
            enclk_d     = '0;
            sys_reset_d = 1'b1;
            locked_d    = 1'b0;
            fail_d      = 1'b0;
            retry_d     = '0;
            // a lock drop seen in RUN on the same cycle still marks the loss
            lock_lost_d = (state_q == S_RUN) && !lock_s;
        end else begin
            case (state_q)
                S_RESET_PLL: begin
                    pll_reset_d = 1'b1;
                    enclk_d     = '0;
                    sys_reset_d = 1'b1;
                    locked_d    = 1'b0;
                    if (cnt_q >= CNT_W'(RST_CYCLES - 1)) begin
                        state_d     = S_WAIT_LOCK;
                        cnt_d       = '0;
                        pll_reset_d = 1'b0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                S_WAIT_LOCK: begin
                    if (lock_s) begin
                        if (LOCK_FILT <= 1) begin
                            state_d = S_ENABLE;
                            cnt_d   = '0;
                            idx_d   = '0;
                            enclk_d = NUM_CLK'(1);
                        end else begin
                            state_d = S_FILTER;
                            cnt_d   = CNT_W'(1);
                        end
                    end else if (cnt_q >= CNT_W'(RELOCK_TIMEOUT - 1)) begin
                        cnt_d       = '0;
                        pll_reset_d = 1'b1;
                        if (retry_cnt >= RETRY_W'(MAX_RETRY)) begin
                            state_d = S_FAIL;
                            fail_d  = 1'b1;
                        end else begin
                            state_d = S_RESET_PLL;
                            retry_d = retry_cnt + RETRY_W'(1);
                        end
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                S_FILTER: begin
                    if (!lock_s) begin
                        state_d = S_WAIT_LOCK;
                        cnt_d   = '0;
                    end else if (cnt_q >= CNT_W'(LOCK_FILT - 1)) begin
                        state_d = S_ENABLE;
                        cnt_d   = '0;
                        idx_d   = '0;
                        enclk_d = NUM_CLK'(1);
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                S_ENABLE: begin
                    if (!lock_s) begin
                        // enables drop on the same edge the PLL reset rises
                        state_d     = S_RESET_PLL;
                        cnt_d       = '0;
                        idx_d       = '0;
                        pll_reset_d = 1'b1;
                        enclk_d     = '0;
                        sys_reset_d = 1'b1;
                    end else if (cnt_q >= CNT_W'(ENCLK_GAP - 1)) begin
                        cnt_d = '0;
                        if (idx_q >= IDX_W'(NUM_CLK - 1)) begin
                            state_d     = S_RUN;
                            sys_reset_d = 1'b0;
                            locked_d    = 1'b1;
                            retry_d     = '0;
                        end else begin
                            idx_d   = idx_q + IDX_W'(1);
                            enclk_d = enclk | (NUM_CLK'(1) << idx_d);
                        end
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                S_RUN: begin
                    if (!lock_s) begin
                        state_d     = S_RESET_PLL;
                        cnt_d       = '0;
                        idx_d       = '0;
                        pll_reset_d = 1'b1;
                        enclk_d     = '0;
                        sys_reset_d = 1'b1;
                        locked_d    = 1'b0;
                        lock_lost_d = 1'b1;
                    end
                end
                S_FAIL: begin
                    pll_reset_d = 1'b1;
                    enclk_d     = '0;
                    sys_reset_d = 1'b1;
                    locked_d    = 1'b0;
                    fail_d      = 1'b1;
                end
                default: begin
                    state_d     = S_RESET_PLL;
                    cnt_d       = '0;
                    idx_d       = '0;
                    pll_reset_d = 1'b1;
                    enclk_d     = '0;
                    sys_reset_d = 1'b1;
                    locked_d    = 1'b0;
                    fail_d      = 1'b0;
                end
            endcase
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge clkin) begin
        if (reset) begin
            state_q   <= S_RESET_PLL;
            cnt_q     <= '0;
            idx_q     <= '0;
            pll_reset <= 1'b1;
            enclk     <= '0;
            sys_reset <= 1'b1;
            locked    <= 1'b0;
            fail      <= 1'b0;
            lock_lost <= 1'b0;
            retry_cnt <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            pll_reset <= pll_reset_d;
            enclk     <= enclk_d;
            sys_reset <= sys_reset_d;
            locked    <= locked_d;
            fail      <= fail_d;
            lock_lost <= lock_lost_d;
            retry_cnt <= retry_d;
        end
    end

endmodule

// File: tb/tb_pll_bringup_seq.sv
// Scoreboard bench for pll_bringup_seq: each output change is matched against a
// queued expected value plus the number of cycles since the previous change.
module tb_pll_bringup_seq;

    localparam int TMO = 120;

    logic       clkin = 1'b0;
    logic       reset;
    logic       pll_lock;
    logic       force_relock;
    logic       pll_reset;
    logic [4:0] enclk;
    logic       sys_reset;
    logic       locked;
    logic       fail;
    logic       lock_lost;
    logic [1:0] retry_cnt;

    typedef struct {
        logic [11:0] outs;
        int          dly;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    pll_bringup_seq #(
        .NUM_CLK(5), .RST_CYCLES(4), .LOCK_FILT(8), .ENCLK_GAP(2),
        .RELOCK_TIMEOUT(50), .MAX_RETRY(2)
    ) dut (
        .clkin(clkin), .reset(reset), .pll_lock(pll_lock), .force_relock(force_relock),
        .pll_reset(pll_reset), .enclk(enclk), .sys_reset(sys_reset), .locked(locked),
        .fail(fail), .lock_lost(lock_lost), .retry_cnt(retry_cnt)
    );

    initial forever #5 clkin = ~clkin;

    always @(posedge clkin) cyc <= cyc + 1;

    // Queue one expected output vector and its distance from the previous change
    task automatic push_exp(input logic pr, input logic [4:0] en, input logic sr,
                            input logic lk, input logic fl, input logic ll,
                            input logic [1:0] rc, input int dly, input string name);
        exp_t e;
        e.outs = {pr, en, sr, lk, fl, ll, rc};
        e.dly  = dly;
        e.name = name;
        exp_q.push_back(e);
    endtask

    // Staggered enable ramp followed by the RUN entry, two cycles per step
    task automatic push_enable(input logic ll, input int first_dly, input string tag);
        logic [4:0] en;
        en = 5'b00000;
        for (int i = 0; i < 5; i++) begin
            en = {en[3:0], 1'b1};
            push_exp(1'b0, en, 1'b1, 1'b0, 1'b0, ll, 2'd0, (i == 0) ? first_dly : 2,
                     $sformatf("%s_enclk%0d", tag, i));
        end
        push_exp(1'b0, 5'b11111, 1'b0, 1'b1, 1'b0, ll, 2'd0, 2, $sformatf("%s_run", tag));
    endtask

    // Wait for the scoreboard to empty, then resume on the next falling edge
    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0) begin
            @(posedge clkin);
            n++;
            if (n > 2000) begin
                $display("FAIL drain_hang: %0d expectations still queued", exp_q.size());
                $fatal(1, "bench stuck waiting for outputs");
            end
        end
        @(negedge clkin);
    endtask

    // Monitor: compare every output change with the head of the queue
    initial begin
        logic [11:0] cur;
        logic [11:0] last;
        int          last_cyc;
        exp_t        e;
        last     = 'x;
        last_cyc = 0;
        forever begin
            @(negedge clkin);
            cur = {pll_reset, enclk, sys_reset, locked, fail, lock_lost, retry_cnt};
            if (cur !== last) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_change: cycle %0d got outs=%b, required no change from %b",
                             cyc, cur, last);
                end else begin
                    e = exp_q.pop_front();
                    if (cur !== e.outs || (cyc - last_cyc) != e.dly) begin
                        errors++;
                        $display("FAIL %s: got outs=%b after %0d cycles, required outs=%b after %0d cycles",
                                 e.name, cur, cyc - last_cyc, e.outs, e.dly);
                    end
                end
                last     = cur;
                last_cyc = cyc;
            end else if (exp_q.size() != 0 && (cyc - last_cyc) > TMO) begin
                checks++;
                errors++;
                e = exp_q[0];
                $display("FAIL %s: got no output change within %0d cycles, required outs=%b",
                         e.name, TMO, e.outs);
                exp_q.delete();
                last_cyc = cyc;
            end
        end
    end

    // Outputs listed as (pll_reset, enclk, sys_reset, locked, fail, lock_lost, retry_cnt)
    initial begin
        reset        = 1'b1;
        pll_lock     = 1'b0;
        force_relock = 1'b0;

        // Clean bring-up; lock rises as pll_reset falls, filter ends 2+8 later
        push_exp(1'b1, 5'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1, "reset_values");
        push_exp(1'b0, 5'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 6, "s1_pll_reset_fall");
        push_enable(1'b0, 10, "s1");
        repeat (3) @(negedge clkin);
        reset = 1'b0;
        repeat (4) @(negedge clkin);
        pll_lock = 1'b1;
        drain();

        // One-cycle lock drop in RUN, then re-bring-up with lock_lost sticky
        push_exp(1'b1, 5'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 6, "s2_lock_loss");
        push_exp(1'b0, 5'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 4, "s2_pll_reset_fall");
        push_enable(1'b1, 8, "s2");
        repeat (2) @(negedge clkin);
        pll_lock = 1'b0;
        @(negedge clkin);
        pll_lock = 1'b1;
        drain();

        // force_relock clears lock_lost; then lock drops right after enclk=00011
        push_exp(1'b1, 5'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2, "s3_force_relock");
        push_exp(1'b0, 5'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4, "s3_pll_reset_fall");
        push_exp(1'b0, 5'b00001, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8, "s3_enclk0");
        push_exp(1'b0, 5'b00011, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2, "s3_enclk1");
        push_exp(1'b1, 5'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2, "s3_enable_drop");
        push_exp(1'b0, 5'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4, "s3_pll_reset_fall2");
        push_enable(1'b0, 10, "s3");
        force_relock = 1'b1;
        @(negedge clkin);
        force_relock = 1'b0;
        repeat (13) @(negedge clkin);
        pll_lock = 1'b0;
        repeat (7) @(negedge clkin);
        pll_lock = 1'b1;
        drain();

        // Filter glitch: 5 synchronized-high cycles, 1 low, then 8 fresh ones
        push_exp(1'b1, 5'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2, "s4_force_relock");
        push_exp(1'b0, 5'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4, "s4_pll_reset_fall");
        push_enable(1'b0, 16, "s4");
        force_relock = 1'b1;
        pll_lock     = 1'b0;
        @(negedge clkin);
        force_relock = 1'b0;
        repeat (4) @(negedge clkin);
        pll_lock = 1'b1;
        repeat (5) @(negedge clkin);
        pll_lock = 1'b0;
        @(negedge clkin);
        pll_lock = 1'b1;
        drain();

        // Lock never comes: three 50-cycle windows, retry 1 and 2, then FAIL
        push_exp(1'b1, 5'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2, "s5_force_relock");
        push_exp(1'b0, 5'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4, "s5_window1");
        push_exp(1'b1, 5'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 50, "s5_timeout1");
        push_exp(1'b0, 5'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 4, "s5_window2");
        push_exp(1'b1, 5'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 50, "s5_timeout2");
        push_exp(1'b0, 5'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 4, "s5_window3");
        push_exp(1'b1, 5'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd2, 50, "s5_fail");
        force_relock = 1'b1;
        pll_lock     = 1'b0;
        @(negedge clkin);
        force_relock = 1'b0;
        drain();

        // FAIL holds for a while, then force_relock restarts a full bring-up
        push_exp(1'b1, 5'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 12, "s5_fail_exit");
        push_exp(1'b0, 5'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4, "s5_pll_reset_fall");
        push_enable(1'b0, 10, "s5");
        repeat (10) @(negedge clkin);
        force_relock = 1'b1;
        @(negedge clkin);
        force_relock = 1'b0;
        repeat (4) @(negedge clkin);
        pll_lock = 1'b1;
        drain();

        // force_relock on the same cycle RUN sees lock low: lock_lost stays set
        push_exp(1'b1, 5'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 4, "s6_force_and_drop");
        push_exp(1'b0, 5'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 4, "s6_pll_reset_fall");
        push_enable(1'b1, 8, "s6");
        pll_lock = 1'b0;
        repeat (2) @(negedge clkin);
        force_relock = 1'b1;
        @(negedge clkin);
        force_relock = 1'b0;
        pll_lock     = 1'b1;
        drain();

        // Reset asserted in RUN returns every output to its reset value
        push_exp(1'b1, 5'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2, "s7_reset_in_run");
        push_exp(1'b0, 5'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4, "s7_pll_reset_fall");
        push_enable(1'b0, 8, "s7");
        reset = 1'b1;
        @(negedge clkin);
        reset = 1'b0;
        drain();

        repeat (20) @(negedge clkin);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
